// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and helpers for the cacheline port arbiter.
package cacheline_arb_types;

    // Widest address the pending table can hold; narrower ports zero-extend.
    localparam int MAX_ADDR_WIDTH = 64;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] line_addr;
    } pend_entry_t;

    // Clear the intra-line byte offset so addresses compare at line granularity.
    function automatic logic [MAX_ADDR_WIDTH-1:0] line_addr_of(
        input logic [MAX_ADDR_WIDTH-1:0] addr,
        input int unsigned               offset_bits
    );
        logic [MAX_ADDR_WIDTH-1:0] mask;
        mask = '1;
        mask = mask << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/cacheline_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arbiter_2
    import cacheline_arb_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       accept,
    output logic [1:0] grant
);

    req_id_t ptr;

    // Grant the sole eligible requester, or the pointer's choice on a tie.
    always_comb begin
        grant = elig;
        if (elig[REQ_I] && elig[REQ_D]) begin
            grant      = '0;
            grant[ptr] = 1'b1;
        end
    end

    // Hand priority to the other side only once a grant is actually accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= REQ_D;
        end else if (accept && (grant != 2'b00)) begin
            ptr <= grant[REQ_I] ? REQ_D : REQ_I;
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between the icache and the dcache,
// tracking one outstanding read per requester and routing fills by address.
module cacheline_arbiter
    import cacheline_arb_types::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic                  i_ready,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_read,
    output logic                  m_write,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic [ADDR_WIDTH-1:0] m_raddr,
    input  logic [LINE_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    output logic                  orphan_resp
);

    pend_entry_t [1:0]         pend;
    logic [MAX_ADDR_WIDTH-1:0] i_line, d_line, r_line;
    logic [1:0]                hit, elig, grant;
    logic                      wr_hazard;

    assign i_line = line_addr_of(MAX_ADDR_WIDTH'(i_addr),  unsigned'(OFFSET_BITS));
    assign d_line = line_addr_of(MAX_ADDR_WIDTH'(d_addr),  unsigned'(OFFSET_BITS));
    assign r_line = line_addr_of(MAX_ADDR_WIDTH'(m_raddr), unsigned'(OFFSET_BITS));

    // A returning line is delivered to every requester waiting on that line.
    assign hit[REQ_I] = m_rvalid && pend[REQ_I].valid && (pend[REQ_I].line_addr == r_line);
    assign hit[REQ_D] = m_rvalid && pend[REQ_D].valid && (pend[REQ_D].line_addr == r_line);

    // Writing back a line the icache is still fetching would race the fill.
    assign wr_hazard = pend[REQ_I].valid && (pend[REQ_I].line_addr == d_line);

    // Nothing is granted while reset is held so no handshake leaks through.
    assign elig[REQ_I] = rst && i_read && !pend[REQ_I].valid;
    assign elig[REQ_D] = rst && ((d_read && !pend[REQ_D].valid) || (d_write && !wr_hazard));

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .elig   (elig),
        .accept (m_ready),
        .grant  (grant)
    );

    assign i_ready  = grant[REQ_I] && m_ready;
    assign d_ready  = grant[REQ_D] && m_ready;
    assign i_rvalid = hit[REQ_I];
    assign d_rvalid = hit[REQ_D];
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign m_wdata  = d_wdata;

    // Steer the granted request onto the memory port.
    always_comb begin
        m_addr  = ADDR_WIDTH'(d_line);
        m_read  = 1'b0;
        m_write = 1'b0;
        if (grant[REQ_I]) begin
            m_addr = ADDR_WIDTH'(i_line);
            m_read = 1'b1;
        end else if (grant[REQ_D]) begin
            m_read  = d_read;
            m_write = d_write;
        end
    end

    // Retire entries on their fill and allocate on accepted reads; a requester
    // cannot be eligible while its own entry is valid, so both never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            if (hit[REQ_I]) pend[REQ_I].valid <= 1'b0;
            if (hit[REQ_D]) pend[REQ_D].valid <= 1'b0;
            if (i_ready) begin
                pend[REQ_I].valid     <= 1'b1;
                pend[REQ_I].line_addr <= i_line;
            end
            if (d_ready && d_read) begin
                pend[REQ_D].valid     <= 1'b1;
                pend[REQ_D].line_addr <= d_line;
            end
        end
    end

    // Sticky flag for fills nobody was waiting for; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            orphan_resp <= 1'b0;
        end else if (m_rvalid && (hit == 2'b00)) begin
            orphan_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench: the driver predicts each cycle's outputs with a
// behavioural model and queues them; a negedge monitor compares.
module tb_cacheline_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam logic [AW-1:0] LMASK = 32'hFFFF_FFE0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0, m_addr, m_raddr = '0;
    logic          i_read = 0, i_ready, i_rvalid;
    logic          d_read = 0, d_write = 0, d_ready, d_rvalid;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata = '0, m_wdata, m_rdata = '0;
    logic          m_read, m_write, m_ready = 0, m_rvalid = 0, orphan_resp;

    always #5 clk = ~clk;

    cacheline_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_ready(i_ready), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata), .m_ready(m_ready),
        .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .orphan_resp(orphan_resp)
    );

    typedef struct packed {
        logic          i_ready, d_ready, m_read, m_write, i_rvalid, d_rvalid, orphan;
        logic [AW-1:0] m_addr;
        logic [LW-1:0] m_wdata, rdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] mem_q[$];
    int            n_checks = 0, n_fail = 0;

    // Reference state: index 0 = icache, 1 = dcache; prio names the tie winner.
    bit            pv[2];
    logic [AW-1:0] pa[2];
    int            prio = 1;
    bit            orph = 0;
    bit            acc_i, acc_d;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs from the current inputs, then advance state.
    task automatic model_step();
        exp_t          e;
        logic [AW-1:0] ra;
        bit            im, dm, ie, de, haz, acc;
        int            win;
        e = '0;
        acc_i = 0;
        acc_d = 0;
        if (!rst) begin
            pv[0] = 0; pv[1] = 0; prio = 1; orph = 0;
            exp_q.push_back(e);
            return;
        end
        ra  = m_raddr & LMASK;
        im  = m_rvalid && pv[0] && (pa[0] == ra);
        dm  = m_rvalid && pv[1] && (pa[1] == ra);
        ie  = i_read && !pv[0];
        haz = pv[0] && (pa[0] == (d_addr & LMASK));
        de  = (d_read && !pv[1]) || (d_write && !haz);
        win = (ie && de) ? prio : ie ? 0 : de ? 1 : -1;
        acc = (win >= 0) && m_ready;
        e.i_ready  = acc && (win == 0);
        e.d_ready  = acc && (win == 1);
        e.m_read   = (win == 0) || ((win == 1) && d_read);
        e.m_write  = (win == 1) && d_write;
        e.m_addr   = ((win == 0) ? i_addr : d_addr) & LMASK;
        e.m_wdata  = d_wdata;
        e.i_rvalid = im;
        e.d_rvalid = dm;
        e.rdata    = m_rdata;
        e.orphan   = orph;
        exp_q.push_back(e);
        if (m_rvalid && !im && !dm) orph = 1;
        if (im) pv[0] = 0;
        if (dm) pv[1] = 0;
        acc_i = e.i_ready;
        acc_d = e.d_ready;
        if (acc_i) begin pv[0] = 1; pa[0] = i_addr & LMASK; mem_q.push_back(pa[0]); end
        if (acc_d && d_read) begin pv[1] = 1; pa[1] = d_addr & LMASK; mem_q.push_back(pa[1]); end
        if (acc) prio = 1 - win;
    endtask

    // One clock: predict, advance, and let requesters drop accepted requests.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        if (acc_i) i_read = 0;
        if (acc_d) begin d_read = 0; d_write = 0; end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] base;
        case ($urandom_range(0, 5))
            0: base = 32'h0000_0080;
            1: base = 32'h0000_0100;
            2: base = 32'h0000_0240;
            3: base = 32'h0000_03C0;
            4: base = 32'h0000_0500;
            default: base = $urandom & LMASK;
        endcase
        return base | AW'($urandom_range(0, 31));
    endfunction

    task automatic respond(input logic [AW-1:0] a);
        m_rvalid = 1;
        m_raddr  = a;
        m_rdata  = rand_line();
        step();
        m_rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        steps(2);
        rst = 1;
    endtask

    task automatic rand_cycle();
        int idx;
        if (!i_read && ($urandom_range(0, 2) == 0)) begin
            i_read = 1;
            i_addr = rand_addr();
        end
        if (!d_read && !d_write) begin
            case ($urandom_range(0, 3))
                0: begin d_read = 1; d_addr = rand_addr(); end
                1: begin d_write = 1; d_addr = rand_addr(); d_wdata = rand_line(); end
                default: ;
            endcase
        end
        m_ready  = ($urandom_range(0, 3) != 0);
        m_rvalid = 0;
        if (mem_q.size() > 0 && ($urandom_range(0, 2) == 0)) begin
            idx      = $urandom_range(0, mem_q.size() - 1);
            m_rvalid = 1;
            m_raddr  = mem_q[idx] | AW'($urandom_range(0, 31));
            m_rdata  = rand_line();
            mem_q.delete(idx);
        end else if ($urandom_range(0, 39) == 0) begin
            m_rvalid = 1;
            m_raddr  = rand_addr();
            m_rdata  = rand_line();
        end
        step();
        m_rvalid = 0;
    endtask

    // Monitor: every cycle the DUT outputs are held against the queued prediction.
    exp_t me;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("i_ready",     LW'(i_ready),     LW'(me.i_ready));
            chk("d_ready",     LW'(d_ready),     LW'(me.d_ready));
            chk("m_read",      LW'(m_read),      LW'(me.m_read));
            chk("m_write",     LW'(m_write),     LW'(me.m_write));
            chk("i_rvalid",    LW'(i_rvalid),    LW'(me.i_rvalid));
            chk("d_rvalid",    LW'(d_rvalid),    LW'(me.d_rvalid));
            chk("orphan_resp", LW'(orphan_resp), LW'(me.orphan));
            if (me.m_read || me.m_write) chk("m_addr", LW'(m_addr), LW'(me.m_addr));
            if (me.m_write)  chk("m_wdata", m_wdata, me.m_wdata);
            if (me.i_rvalid) chk("i_rdata", i_rdata, me.rdata);
            if (me.d_rvalid) chk("d_rdata", d_rdata, me.rdata);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        steps(2);
        rst = 1;

        // Both read out of reset: dcache first, icache next.
        i_read = 1; i_addr = 32'h100;
        d_read = 1; d_addr = 32'h200;
        m_ready = 1;
        steps(3);
        respond(32'h200);
        respond(32'h104);

        // Dcache fill routing; a second dcache read waits for the first fill.
        d_read = 1; d_addr = 32'h240;
        step();
        d_read = 1; d_addr = 32'h260;
        steps(3);
        respond(32'h25F);
        steps(2);
        respond(32'h260);

        // Writeback hazard against a pending icache fetch of the same line.
        i_read = 1; i_addr = 32'h80;
        step();
        d_write = 1; d_addr = 32'h88; d_wdata = rand_line();
        steps(3);
        respond(32'h9C);
        steps(2);

        // One fill satisfies both requesters waiting on the same line.
        i_read = 1; i_addr = 32'h3C4;
        d_read = 1; d_addr = 32'h3D0;
        steps(3);
        respond(32'h3C0);
        steps(2);

        // Memory stalls: no handshake, priority preserved across the stall.
        m_ready = 0;
        i_read = 1; i_addr = 32'h700;
        d_read = 1; d_addr = 32'h900;
        steps(5);
        m_ready = 1;
        steps(3);
        respond(32'h700);
        respond(32'h900);

        // Reset with an icache read outstanding: the late fill is an orphan.
        i_read = 1; i_addr = 32'h500;
        step();
        do_reset();
        step();
        respond(32'h500);
        steps(4);

        // Randomised traffic with periodic resets.
        mem_q.delete();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ((c % 600) == 599) do_reset();
            else rand_cycle();
        end
        i_read = 0; d_read = 0; d_write = 0; m_rvalid = 0;
        steps(2);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares the single downstream cacheline memory port between the instruction cache (read-only) and the data cache (read and writeback).
- Sits between both caches' downward-facing ports and the memory/burst controller.
- Arbitrates round-robin and tracks one outstanding read per requester.
- Routes each read response back to its requester(s) by matching the returned line address.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the cacheline port.
- LINE_WIDTH, 256, cacheline data width in bits.
- OFFSET_BITS, 5, low address bits forced to zero (log2 of line bytes).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_addr  in  ADDR_WIDTH  icache line address.
- i_read  in  1  icache read request.
- i_ready  out  1  icache request accepted this cycle.
- i_rdata  out  LINE_WIDTH  icache fill data.
- i_rvalid  out  1  icache fill valid.
- d_addr  in  ADDR_WIDTH  dcache line address.
- d_read  in  1  dcache read request.
- d_write  in  1  dcache writeback request.
- d_wdata  in  LINE_WIDTH  dcache writeback data.
- d_ready  out  1  dcache request accepted this cycle.
- d_rdata  out  LINE_WIDTH  dcache fill data.
- d_rvalid  out  1  dcache fill valid.
- m_addr  out  ADDR_WIDTH  memory address.
- m_read  out  1  memory read.
- m_write  out  1  memory write.
- m_wdata  out  LINE_WIDTH  memory write data.
- m_ready  in  1  memory accepts request this cycle.
- m_raddr  in  ADDR_WIDTH  address of returning line.
- m_rdata  in  LINE_WIDTH  returning line.
- m_rvalid  in  1  returning line valid.
- orphan_resp  out  1  sticky: a response matched no pending read.

Behaviour:
- Handshake: a requester holds addr/read/write/wdata stable until its ready is high. Acceptance = grant and m_ready in the same cycle. Grant is combinational, zero added latency.
- d_read and d_write are never both high (protocol error, not checked).
- Eligibility, icache: i_read high and no icache read pending.
- Eligibility, dcache: (d_read high and no dcache read pending) or d_write high.
- Write hazard: a d_write whose line address equals a pending icache read address is ineligible until that response returns.
- Arbitration: one eligible requester wins. If both are eligible, the priority pointer decides. The pointer flips to the other requester only on an accepted grant. Pointer reset value = dcache.
- Output mux: m_addr = granted addr with the low OFFSET_BITS zeroed. m_read/m_write reflect the granted request. With no grant, m_read = m_write = 0 and m_addr/m_wdata are don't-care.
- Pending table: one entry {valid, line_addr} per requester. An accepted read sets the entry; an accepted write does not allocate.
- Response routing: when m_rvalid is high, compare m_raddr (offset masked) against each valid entry.
  - Each match: drive that port's rvalid high for exactly that cycle with rdata = m_rdata, and clear the entry the next edge.
  - Both entries match: deliver to both in the same cycle and clear both.
  - No match: drop the data and set orphan_resp.
- Simultaneous events: an entry cleared by a response in cycle N may be re-set by an accepted read from the same requester in cycle N+1, not in N.
- Reset values: all pending valid = 0; pointer = dcache; orphan_resp = 0; i_rvalid = d_rvalid = 0; i_ready = d_ready = 0.
- Reset mid-operation: the pending table is cleared. Responses arriving after reset are orphans: dropped, with orphan_resp set.
- orphan_resp clears only on reset.

Decomposition:
- Shared package cacheline_arb_types:
  - req_id_t enum {REQ_I, REQ_D}.
  - pend_entry_t struct {valid, line_addr}.
  - Line-address masking function.
- Sub-module rr_arbiter_2: two eligibility inputs, accept strobe, one-hot grant output, internal pointer register.

Test Plan:
- Both read at reset (i_addr=0x100, d_addr=0x200), m_ready=1 -> d_ready first (pointer=dcache), i_ready the next cycle; m_addr 0x200 then 0x100.
- d_read 0x240 pending, then m_rvalid with m_raddr=0x240 -> d_rvalid for one cycle with d_rdata=m_rdata, i_rvalid=0; a second d_read is ready-blocked until that cycle.
- Icache pending 0x80 and dcache writeback to 0x80 -> d_ready held low until the 0x80 response; writeback accepted the cycle after i_rvalid.
- Both reads pending to 0x3C0 -> a single response asserts i_rvalid and d_rvalid together; both entries cleared.
- m_ready=0 for 5 cycles with both requesting -> no ready asserted and pointer unchanged; first ready goes to the prior-priority requester.
- Reset asserted with icache read 0x500 pending, then response 0x500 -> i_rvalid stays 0 and orphan_resp rises and stays high.
